// File: rtl/vga_fb_scanout_pkg.sv
// vga_fb_scanout_pkg: shared frame-buffer geometry, 640x480@60 VGA timing, colour constants and address helper
package vga_fb_scanout_pkg;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int COLOUR_W    = 3;
  localparam int FB_DEPTH    = FB_W * FB_H;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  typedef logic [14:0] addr_t;
  typedef logic [COLOUR_W-1:0] colour_t;
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;
  localparam colour_t BLACK    = 3'b000;
  localparam sync_t   SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
  // row*160 + col, with the multiply as (row<<7)+(row<<5) so no multiplier is inferred
  function automatic addr_t fb_addr(input logic [6:0] row, input logic [7:0] col);
    return {1'b0, row, 7'b0} + {3'b0, row, 5'b0} + {7'b0, col};
  endfunction
endpackage

// File: rtl/vga_fb_scanout_if.sv
// vga_fb_scanout_if: pixel-plot write bus from a drawer (master) into the frame buffer (slave)
// Signals: wren write strobe, x column 0..159, y row 0..119, colourIn {R,G,B}
interface vga_fb_scanout_if;
  logic       wren;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colourIn;
  modport master (output wren, x, y, colourIn);
  modport slave  (input  wren, x, y, colourIn);
endinterface

// File: rtl/vga_fb_scanout_fb_ram_dp.sv
// vga_fb_scanout_fb_ram_dp: simple dual-port frame-buffer RAM, one write port, one registered read port
// Ports: clk; we/wa/wd write; re/ra read request, rd registered data (old data on same-address write)
module vga_fb_scanout_fb_ram_dp
  import vga_fb_scanout_pkg::*;
(
  input  logic    clk,
  input  logic    we,
  input  addr_t   wa,
  input  colour_t wd,
  input  logic    re,
  input  addr_t   ra,
  output colour_t rd
);
  colour_t mem [FB_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 160x120x3 frame buffer written by the drawers, scanned out as 640x480@60 VGA, 4x replicated
// Ports: clk 50 MHz; rst async active-low; wr pixel-plot write bus (slave);
//   vga_r/g/b 8-bit channels, vga_hs/vga_vs active-low syncs, vga_blank_n, frame_done start-of-vblank pulse.
// Option VGA_FB_SCANOUT_TESTPAT_EN adds input testpat: visible area shows h_cnt[9:7] colour bars instead of RAM.
module vga_fb_scanout
  import vga_fb_scanout_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  vga_fb_scanout_if.slave         wr,
`ifdef VGA_FB_SCANOUT_TESTPAT_EN
  input  logic                    testpat,
`endif
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank_n,
  output logic                    frame_done
);
  logic    pix_tick;
  logic    [9:0] h_cnt, v_cnt;
  logic    h_last, v_last, vis, we;
  addr_t   rd_addr;
  sync_t   s0, s1, s2;
  colour_t rd_data, pix, colour;
  always_comb begin
    h_last     = h_cnt == 10'(H_TOTAL - 1);
    v_last     = v_cnt == 10'(V_TOTAL - 1);
    vis        = h_cnt < 10'(H_VIS) && v_cnt < 10'(V_VIS);
    s0.hs      = !(h_cnt >= 10'(H_VIS + H_FP) && h_cnt < 10'(H_VIS + H_FP + H_SYNC));
    s0.vs      = !(v_cnt >= 10'(V_VIS + V_FP) && v_cnt < 10'(V_VIS + V_FP + V_SYNC));
    s0.blank_n = vis;
    we         = wr.wren && wr.x < 8'(FB_W) && wr.y < 7'(FB_H);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_tick   <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      rd_addr    <= '0;
      s1         <= SYNC_RST;
      s2         <= SYNC_RST;
      frame_done <= 1'b0;
    end else begin
      pix_tick   <= !pix_tick;
      frame_done <= pix_tick && h_last && v_cnt == 10'(V_VIS - 1);
      if (pix_tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 10'd1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        if (vis) rd_addr <= fb_addr(v_cnt[8:SCALE_SHIFT], h_cnt[9:SCALE_SHIFT]);
        s1 <= s0;
        s2 <= s1;
      end
    end
  end
  // the read is enabled only on pixel ticks so RAM data stays aligned with s2
  vga_fb_scanout_fb_ram_dp u_ram (
    .clk (clk),
    .we  (we),
    .wa  (fb_addr(wr.y, wr.x)),
    .wd  (wr.colourIn),
    .re  (pix_tick),
    .ra  (rd_addr),
    .rd  (rd_data)
  );
`ifdef VGA_FB_SCANOUT_TESTPAT_EN
  colour_t tp1, tp2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tp1 <= '0;
      tp2 <= '0;
    end else if (pix_tick) begin
      tp1 <= h_cnt[9:7];
      tp2 <= tp1;
    end
  end
  assign pix = testpat ? tp2 : rd_data;
`else
  assign pix = rd_data;
`endif
  always_comb begin
    colour      = s2.blank_n ? pix : BLACK;
    vga_r       = {8{colour[2]}};
    vga_g       = {8{colour[1]}};
    vga_b       = {8{colour[0]}};
    vga_hs      = s2.hs;
    vga_vs      = s2.vs;
    vga_blank_n = s2.blank_n;
  end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: scoreboard bench for vga_fb_scanout against a position-based screen model
module tb_vga_fb_scanout;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  vga_fb_scanout_if wr_if ();
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank_n, frame_done;
  vga_fb_scanout dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr_if),
`ifdef VGA_FB_SCANOUT_TESTPAT_EN
    .testpat     (1'b0),
`endif
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_done  (frame_done)
  );
  typedef struct packed {
    logic [7:0] r, g, b;
    logic hs, vs, bn, fd;
  } pins_t;
  pins_t exp_q[$];
  logic [2:0] fb [19200];
  int e = 0;
  int checks = 0;
  int passes = 0;
  // screen state shown on the pins after pixel tick t (ticks are every second clk after release)
  function automatic pins_t expect_at(int t);
    pins_t p;
    int pos, h, v;
    logic [2:0] c;
    p = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    if (t < 2) return p;
    pos  = t - 2;
    h    = pos % 800;
    v    = (pos / 800) % 525;
    p.bn = h < 640 && v < 480;
    c    = p.bn ? fb[(v / 4) * 160 + h / 4] : 3'b000;
    p.r  = {8{c[2]}};
    p.g  = {8{c[1]}};
    p.b  = {8{c[0]}};
    p.hs = !(h >= 656 && h < 752);
    p.vs = !(v >= 490 && v < 492);
    p.fd = (t % 420000) == 384000;
    return p;
  endfunction
  initial forever begin
    @(posedge clk);
    if (!rst) e = 0;
    else begin
      e++;
      if (e % 2 == 0) exp_q.push_back(expect_at(e / 2));
    end
    if (wr_if.wren === 1'b1 && wr_if.x < 160 && wr_if.y < 120)
      fb[int'(wr_if.y) * 160 + int'(wr_if.x)] = wr_if.colourIn;
  end
  initial forever begin
    pins_t act, ex;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      act = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_done};
      checks++;
      if (act !== ex) $display("FAIL pixel edge=%0d got=%h expected=%h", e, act, ex);
      else passes++;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    else passes++;
  endtask
  task automatic wr(input int xx, input int yy, input logic [2:0] c);
    @(negedge clk);
    wr_if.wren     = 1'b1;
    wr_if.x        = 8'(xx);
    wr_if.y        = 7'(yy);
    wr_if.colourIn = c;
  endtask
  task automatic idle();
    @(negedge clk);
    wr_if.wren = 1'b0;
  endtask
  task automatic chk_reset_pins(input string tag);
    chk({tag, "_hs"}, vga_hs, 1);
    chk({tag, "_vs"}, vga_vs, 1);
    chk({tag, "_blank_n"}, vga_blank_n, 0);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask
  task automatic measure(input string tag);
    int first = -1, second = -1, low = 0, bl = 0;
    logic prev = 1'b1;
    for (int i = 1; i <= 3300; i++) begin
      @(posedge clk);
      #1;
      if (prev && !vga_hs) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      prev = vga_hs;
      if (i <= 1600) begin
        if (!vga_hs) low++;
        if (vga_blank_n) bl++;
      end
    end
    chk({tag, "_hs_first_fall"}, first, 1316);
    chk({tag, "_hs_period"}, second - first, 1600);
    chk({tag, "_hs_low_clks"}, low, 192);
    chk({tag, "_blank_hi_clks"}, bl, 1280);
  endtask
  task automatic random_writes(input int stop_e);
    for (int i = 0; i < 40000 && e < stop_e; i++) begin
      @(negedge clk);
      wr_if.wren     = $urandom_range(0, 3) != 0;
      wr_if.x        = 8'($urandom_range(0, 175));
      wr_if.y        = 7'(($urandom_range(0, 7) == 0) ? $urandom_range(120, 127) : $urandom_range(3, 15));
      wr_if.colourIn = 3'($urandom);
    end
    idle();
  endtask
  task automatic wait_edge(input int target);
    for (int i = 0; i < 40000 && e != target; i++) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d", e);
    $fatal(1, "watchdog");
  end
  initial begin
    wr_if.wren = 1'b0;
    wr_if.x = '0;
    wr_if.y = '0;
    wr_if.colourIn = '0;
    repeat (3) @(negedge clk);
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < 160; xx++) wr(xx, yy, 3'($urandom));
    wr(0, 0, 3'b100);
    wr(1, 0, 3'b000);
    wr(0, 1, 3'b000);
    wr(10, 2, 3'b101);
    wr(159, 119, 3'b011);
    idle();
    chk_reset_pins("por");
    @(negedge clk);
    rst = 1'b1;
    fork
      measure("line");
      begin
        wr(160, 0, 3'b111);
        wr(0, 120, 3'b111);
        random_writes(12000);
      end
    join
    wait_edge(12883);
    wr_if.wren     = 1'b1;
    wr_if.x        = 8'd10;
    wr_if.y        = 7'd2;
    wr_if.colourIn = 3'b010;
    idle();
    random_writes(21000);
    wait_edge(21401);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_pins("midline");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    measure("rerun");
    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
